// File: rtl/serial_adder.sv
// Digit-serial adder: adds DIGIT bits per clock over WIDTH/DIGIT cycles, LSB digit first.
// Optional subtract mode (A + ~B + 1) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             Clk,
  input  logic             Reset_b,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Busy,
  output logic             Done
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_carry;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // Subtraction loads the inverted addend and forces the carry-in to 1.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = Sub ? ~B : B;
  assign c_load = Sub ? 1'b1 : Cin;
`else
  assign b_load = B;
  assign c_load = Cin;
`endif

  // Ripple chain of DIGIT full-adder cells fed by the carry flop.
  always_comb begin
    dig_carry = carry_q;
    dig_sum   = '0;
    for (int i = 0; i < DIGIT; i++) begin
      dig_sum[i] = a_q[i] ^ b_q[i] ^ dig_carry;
      dig_carry  = (a_q[i] & b_q[i]) | (dig_carry & (a_q[i] ^ b_q[i]));
    end
  end

  // Result digits enter from the MSB side so the first digit ends up at the LSB.
  if (DIGIT == WIDTH) begin : g_full
    assign sum_next = dig_sum;
  end else begin : g_part
    assign sum_next = {dig_sum, sum_q[WIDTH-1:DIGIT]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (Start) begin
          state_d = S_RUN;
          a_d     = A;
          b_d     = b_load;
          carry_d = c_load;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sum_d   = sum_next;
        carry_d = dig_carry;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          cout_d  = dig_carry;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_b) begin
    if (!Reset_b) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random bench for serial_adder across DIGIT = 1, 2, 4, 8, 16 (WIDTH = 16).
// Subtract vectors are exercised when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

  localparam int W = 16;
  localparam int DIG [5] = '{1, 2, 4, 8, 16};

  logic          clk_sys = 1'b0;
  logic          rst_b;
  logic          start [5];
  logic [W-1:0]  a_in, b_in;
  logic          cin, sub;
  logic [W-1:0]  sum [5];
  logic          cout [5], busy [5], done [5];

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  serial_adder #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .Clk(clk_sys), .Reset_b(rst_b), .Start(start[0]), .A(a_in), .B(b_in), .Cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub(sub),
`endif
    .Sum(sum[0]), .Cout(cout[0]), .Busy(busy[0]), .Done(done[0]));
  serial_adder #(.WIDTH(W), .DIGIT(2)) u_d2 (
    .Clk(clk_sys), .Reset_b(rst_b), .Start(start[1]), .A(a_in), .B(b_in), .Cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub(sub),
`endif
    .Sum(sum[1]), .Cout(cout[1]), .Busy(busy[1]), .Done(done[1]));
  serial_adder #(.WIDTH(W), .DIGIT(4)) u_d4 (
    .Clk(clk_sys), .Reset_b(rst_b), .Start(start[2]), .A(a_in), .B(b_in), .Cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub(sub),
`endif
    .Sum(sum[2]), .Cout(cout[2]), .Busy(busy[2]), .Done(done[2]));
  serial_adder #(.WIDTH(W), .DIGIT(8)) u_d8 (
    .Clk(clk_sys), .Reset_b(rst_b), .Start(start[3]), .A(a_in), .B(b_in), .Cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub(sub),
`endif
    .Sum(sum[3]), .Cout(cout[3]), .Busy(busy[3]), .Done(done[3]));
  serial_adder #(.WIDTH(W), .DIGIT(16)) u_d16 (
    .Clk(clk_sys), .Reset_b(rst_b), .Start(start[4]), .A(a_in), .B(b_in), .Cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub(sub),
`endif
    .Sum(sum[4]), .Cout(cout[4]), .Busy(busy[4]), .Done(done[4]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One operation on instance k; poke re-asserts Start with other operands mid-RUN.
  task automatic run_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input bit poke,
                        output logic [W:0] res, output int lat, output int bcnt);
    @(negedge clk_sys);
    start[k] = 1'b1; a_in = a; b_in = b; cin = c;
    @(posedge clk_sys); #1;
    start[k] = 1'b0;
    a_in = ~a; b_in = a ^ b; cin = ~c;
    bcnt = busy[k] ? 1 : 0;
    lat  = 0;
    while (!done[k] && lat < 40) begin
      @(posedge clk_sys); #1;
      lat++;
      if (busy[k]) bcnt++;
      start[k] = (poke && lat == 1);
      if (poke && lat == 1) begin
        a_in = 16'hAAAA; b_in = 16'h5555;
      end
    end
    start[k] = 1'b0;
    res = {cout[k], sum[k]};
  endtask

  logic [W:0]  res, exp17;
  int          lat, bcnt;
  bit          seen;
  logic [W-1:0] ra, rb;
  logic        rc;

  initial begin
    for (int i = 0; i < 5; i++) start[i] = 1'b0;
    a_in = '0; b_in = '0; cin = 1'b0; sub = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_sum", sum[0], 0);
    check("rst_cout", cout[0], 0);
    check("rst_busy", busy[2], 0);
    check("rst_done", done[4], 0);
    @(negedge clk_sys);
    rst_b = 1'b1;

    // Ripple through all 16 bits, DIGIT=1.
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, res, lat, bcnt);
    check("d1_sum", res[W-1:0], 16'h0000);
    check("d1_cout", res[W], 1);
    check("d1_lat", lat, 16);
    check("d1_busy_cycles", bcnt, 16);
    @(posedge clk_sys); #1;
    check("d1_done_pulse", done[0], 0);
    a_in = 16'h1357; b_in = 16'h2468;
    repeat (3) @(posedge clk_sys); #1;
    check("d1_hold_sum", sum[0], 16'h0000);
    check("d1_hold_cout", cout[0], 1);

    // DIGIT=4 with a Start poke during RUN.
    run_op(2, 16'h1234, 16'h4321, 1'b1, 1'b1, res, lat, bcnt);
    check("d4_sum", res[W-1:0], 16'h5556);
    check("d4_cout", res[W], 0);
    check("d4_lat", lat, 4);
    @(posedge clk_sys); #1;
    check("d4_poke_no_restart", busy[2], 0);
    check("d4_poke_sum_held", sum[2], 16'h5556);

    // Back-to-back: Start held through Done.
    @(negedge clk_sys);
    start[2] = 1'b1; a_in = 16'h0001; b_in = 16'h0002; cin = 1'b0;
    @(posedge clk_sys); #1;
    a_in = 16'h0100; b_in = 16'h0020; cin = 1'b1;
    lat = 0;
    while (!done[2] && lat < 40) begin
      @(posedge clk_sys); #1; lat++;
    end
    check("b2b_lat1", lat, 4);
    check("b2b_sum1", sum[2], 16'h0003);
    @(posedge clk_sys); #1;
    check("b2b_busy", busy[2], 1);
    check("b2b_done_low", done[2], 0);
    start[2] = 1'b0;
    lat = 0;
    while (!done[2] && lat < 40) begin
      @(posedge clk_sys); #1; lat++;
    end
    check("b2b_lat2", lat, 4);
    check("b2b_sum2", sum[2], 16'h0121);
    check("b2b_cout2", cout[2], 0);

    // Reset asserted in the 7th RUN cycle.
    @(negedge clk_sys);
    start[0] = 1'b1; a_in = 16'h00FF; b_in = 16'h0000; cin = 1'b0;
    @(posedge clk_sys); #1;
    start[0] = 1'b0;
    repeat (6) @(posedge clk_sys);
    #1;
    rst_b = 1'b0;
    #1;
    check("mid_rst_sum", sum[0], 0);
    check("mid_rst_cout", cout[0], 0);
    check("mid_rst_busy", busy[0], 0);
    check("mid_rst_done", done[0], 0);
    @(negedge clk_sys);
    @(negedge clk_sys);
    rst_b = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk_sys); #1;
      if (done[0] || busy[0]) seen = 1'b1;
    end
    check("mid_rst_no_done", seen, 0);
    run_op(0, 16'h1111, 16'h2222, 1'b0, 1'b0, res, lat, bcnt);
    check("post_rst_sum", res, 17'h03333);
    check("post_rst_lat", lat, 16);

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    run_op(0, 16'h0005, 16'h0007, 1'b1, 1'b0, res, lat, bcnt);
    check("sub_5m7_sum", res[W-1:0], 16'hFFFE);
    check("sub_5m7_cout", res[W], 0);
    run_op(3, 16'h0007, 16'h0005, 1'b0, 1'b0, res, lat, bcnt);
    check("sub_7m5_sum", res[W-1:0], 16'h0002);
    check("sub_7m5_cout", res[W], 1);
    sub = 1'b0;
`endif

    // Random operands on every DIGIT setting.
    for (int k = 0; k < 5; k++) begin
      for (int n = 0; n < 1000; n++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom);
        exp17 = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
        run_op(k, ra, rb, rc, 1'b0, res, lat, bcnt);
        check("rand_result", res, exp17);
        check("rand_lat", lat, W / DIG[k]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand width in bits, minimum 2.
REQ-002 The block SHALL have parameter DIGIT, default 1: bits added per clock; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 The block SHALL have port Clk, input, 1 bit: single clock, rising-edge active.
REQ-004 The block SHALL have port Reset_b, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port Start, input, 1 bit: request to begin an addition.
REQ-006 The block SHALL have port A, input, WIDTH bits: augend, sampled with Start.
REQ-007 The block SHALL have port B, input, WIDTH bits: addend, sampled with Start.
REQ-008 The block SHALL have port Cin, input, 1 bit: carry-in, sampled with Start.
REQ-009 The block SHALL have port Sum, output, WIDTH bits: result, registered.
REQ-010 The block SHALL have port Cout, output, 1 bit: carry-out of the MSB, registered.
REQ-011 The block SHALL have port Busy, output, 1 bit: high while an addition is in progress.
REQ-012 The block SHALL have port Done, output, 1 bit: one-cycle pulse when Sum and Cout become valid.

Function
REQ-013 The block SHALL implement three states: IDLE, RUN and DONE; N = WIDTH/DIGIT.
REQ-014 When the state is IDLE or DONE and Start=1 at a rising edge, the block SHALL latch A, B and Cin, clear the digit counter and enter RUN.
REQ-015 In RUN, the block SHALL, on each edge, add the DIGIT least-significant unprocessed bits of A and B plus the carry flop, using ripple logic of DIGIT half/full-adder cells.
REQ-016 In RUN, the block SHALL shift the result digit into Sum from the MSB side and update the carry flop.
REQ-017 The block SHALL increment the digit counter each RUN cycle and wrap it from N-1 to 0.
REQ-018 When the counter wraps, the block SHALL write the final carry to Cout and enter DONE.
REQ-019 Latency: for Start sampled at edge t, Sum and Cout SHALL be valid and Done SHALL be high in the cycle after edge t+N.
REQ-020 Done SHALL be high for exactly one cycle; the FSM SHALL return from DONE to IDLE unless Start=1, which begins a new operation back-to-back.
REQ-021 Busy SHALL be 1 exactly while in RUN.
REQ-022 Start=1 during RUN SHALL be ignored, and operand inputs SHALL have no effect outside the Start edge.
REQ-023 Sum and Cout SHALL hold their last result in IDLE and DONE until the next accepted Start.
REQ-024 Sum SHALL equal (A+B+Cin) mod 2^WIDTH and Cout SHALL equal bit WIDTH of A+B+Cin.
REQ-025 With DIGIT=WIDTH, the operation SHALL complete in one RUN cycle (N=1).

Reset
REQ-026 Reset_b=0 SHALL asynchronously force the state to IDLE and clear Sum, Cout, Busy, Done, the carry flop, the counter and the operand registers, including mid-RUN; the operation in flight is discarded.
REQ-027 After Reset_b deasserts, the block SHALL accept Start at the first rising edge.

Configuration
REQ-028 With SERIAL_ADDER_SUB_EN defined, the block SHALL add an input Sub (1 bit, sampled with Start); Sub=1 SHALL compute A + ~B + 1 (Cin ignored), with Cout=1 meaning no borrow.
REQ-029 Without SERIAL_ADDER_SUB_EN, the Sub port SHALL be absent and the block SHALL only add.

Verification
REQ-030 WIDTH=16, DIGIT=1: A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1, Done exactly 16 cycles after Start, Busy high for 16 cycles.
REQ-031 WIDTH=16, DIGIT=4: A=0x1234, B=0x4321, Cin=1 -> Sum=0x5556, Cout=0, Done 4 cycles after Start; Start reasserted during RUN with other operands -> ignored, result unchanged.
REQ-032 Back-to-back: Start held through Done -> second operation starts in the DONE cycle, with no IDLE cycle between them.
REQ-033 Reset_b pulsed low at RUN cycle 7 -> all outputs 0 immediately, no Done; a new Start then completes normally.
REQ-034 With SERIAL_ADDER_SUB_EN: A=0x0005, B=0x0007, Sub=1 -> Sum=0xFFFE, Cout=0; A=7, B=5, Sub=1 -> Sum=0x0002, Cout=1.
REQ-035 1000 random operand sets per DIGIT in {1,2,4,8,16} -> {Cout,Sum} == A+B+Cin, with Done latency == WIDTH/DIGIT.
